rank_sort_engine: RTL
=====================

Name: rank_sort_engine

Overview:
- Hardware counting-sort (rank-sort) accelerator. It produces the rank table and the sorted result array that the CPU test flow currently builds by hand.
- Accepts N unsigned words over a valid/ready input stream. It computes each element's stable rank by pairwise comparison, scatters elements into a result buffer by rank, then streams the sorted array out with its index.
- Sits beside RiscV_SingleCycle as a data-side co-processor stage feeding the sorted results to the bench/memory.

Parameters:
- N, 20, number of elements per sort job (2..64).
- W, 32, element width in bits, unsigned.
- IDXW, $clog2(N), index/rank width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  engine accepting input; equals (state==LOAD).
- in_data  input  W  element value.
- out_valid  output  1  sorted word valid.
- out_ready  input  1  consumer accepts sorted word.
- out_data  output  W  sorted element.
- out_index  output  IDXW  position of out_data in ascending order.
- busy  output  1  high in COUNT, SCATTER, OUT.
- done  output  1  one-cycle pulse after last output handshake.

Behaviour:
- Reset (reset=0, async):
  - state=LOAD, all counters 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_index=0, busy=0, done=0.
  - Array contents are don't-care and are not reset.
- States: LOAD -> COUNT -> SCATTER -> OUT -> LOAD.
- LOAD:
  - Beat accepted when in_valid&&in_ready; arr[ld_cnt]<=in_data, ld_cnt++.
  - On the N-th accept go to COUNT. ld_cnt clears; i=j=0, acc=0.
- COUNT: one comparison per cycle, N*N cycles.
  - acc increments when arr[j]<arr[i] (unsigned), or when arr[j]==arr[i] && j<i.
  - When j==N-1: rank[i]<=final acc, acc<=0, j<=0, i++.
  - After i==N-1, j==N-1 go to SCATTER.
  - Ranks form a permutation of 0..N-1; equal values keep input order (stable).
- SCATTER: N cycles; cycle k writes res[rank[k]]<=arr[k]. Then go to OUT with out_ptr=0.
- OUT:
  - out_valid=1, out_data=res[out_ptr], out_index=out_ptr.
  - out_ptr advances only on out_valid&&out_ready.
  - While out_ready=0, out_data and out_index are held stable.
  - On handshake with out_ptr==N-1: go to LOAD, done=1 for the following cycle, out_valid=0.
- Latency: last input accept at edge k -> first out_valid high in cycle k+N*N+N+1 (421 cycles for N=20).
- in_valid outside LOAD is ignored; in_ready=0 there, no data is captured.
- A new job may begin loading in the same cycle done pulses (in_ready=1).
- Reset mid-job: the job is abandoned immediately; no done; post-reset behaviour equals power-on.
- Arithmetic: acc is IDXW bits and cannot overflow (max N-1). Comparison is unsigned over full W.

Decomposition:
- Shared package rank_sort_pkg:
  - state encoding LOAD=2'd0, COUNT=2'd1, SCATTER=2'd2, OUT=2'd3
  - default N and W constants
  - IDXW function
- One natural sub-module: sort_buffer, an N×W register array with one synchronous write port and two combinational read ports.
  - Instantiated for arr (reads i and j) and for res (read out_ptr).
  - rank is an N×IDXW array kept in the top.

Test Plan:
- N=20, stream [3,7,2,6,5,4,1,1000,999,25,90,100,30,20,10,200,3300,250,12,75], out_ready=1 -> out_data 1,2,3,4,5,6,7,10,12,20,25,30,75,90,100,200,250,999,1000,3300 with out_index 0..19. First out_valid exactly 421 cycles after last input accept; done pulses once.
- N=4, input [7,7,1,7] -> internal ranks [1,2,0,3]; output 1,7,7,7. Confirm stable ordering by tagging the upper bits of the equal elements.
- Backpressure: during OUT hold out_ready=0 for 5 cycles at out_index=3 -> out_data/out_index unchanged, out_valid stays 1; resumes at index 3 with no skip or duplicate.
- in_valid toggling with gaps during LOAD (e.g. every other cycle) -> only handshaked beats stored; COUNT starts only after the N-th accept. in_valid=1 during COUNT -> in_ready=0, result unaffected.
- Assert reset for one cycle mid-COUNT -> in_ready=1, busy=0, out_valid=0, no done. A following fresh job sorts correctly.
- Back-to-back jobs: second job's first beat accepted in the done cycle -> second job sorted correctly, no data from job 1 leaks.

Source files
------------

// File: rtl/rank_sort_pkg.sv
// rtl/rank_sort_pkg.sv - shared state encoding, default sizes and index-width helper for the rank sort engine
package rank_sort_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COUNT   = 2'd1,
    SCATTER = 2'd2,
    OUT     = 2'd3
  } state_t;

  localparam int DEF_N = 20;
  localparam int DEF_W = 32;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sort_buffer.sv
// rtl/sort_buffer.sv - N x W register array, one synchronous write port, two combinational read ports
module sort_buffer
  import rank_sort_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int W    = DEF_W,
  parameter int IDXW = idx_width(N)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [IDXW-1:0] i_waddr,
  input  logic [W-1:0]    i_wdata,
  input  logic [IDXW-1:0] i_raddr_a,
  input  logic [IDXW-1:0] i_raddr_b,
  output logic [W-1:0]    o_rdata_a,
  output logic [W-1:0]    o_rdata_b
);

  // Contents are job-scoped scratch and are never reset.
  logic [W-1:0] r_mem [N];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/rank_sort_engine.sv
// rtl/rank_sort_engine.sv - counting-sort engine: load N words, rank pairwise, scatter by rank, stream sorted out
module rank_sort_engine
  import rank_sort_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int W    = DEF_W,
  parameter int IDXW = idx_width(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [IDXW-1:0] out_index,
  output logic            busy,
  output logic            done
);

  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
  localparam logic [IDXW-1:0] ONE  = IDXW'(1);

  state_t          r_state;
  state_t          w_next_state;
  logic [IDXW-1:0] r_ld_cnt;
  logic [IDXW-1:0] r_i;
  logic [IDXW-1:0] r_j;
  logic [IDXW-1:0] r_acc;
  logic [IDXW-1:0] r_out_ptr;
  logic            r_done;
  logic [IDXW-1:0] r_rank [N];

  logic [W-1:0]    w_arr_i;
  logic [W-1:0]    w_arr_j;
  logic [W-1:0]    w_res_data;
  logic [W-1:0]    w_res_unused;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_less;
  logic            w_row_end;
  logic [IDXW-1:0] w_acc_next;

  assign w_in_fire  = in_valid && (r_state == LOAD);
  assign w_out_fire = out_ready && (r_state == OUT);
  assign w_row_end  = (r_j == LAST);
  // Ties broken by input position so equal values keep arrival order.
  assign w_less     = (w_arr_j < w_arr_i) || ((w_arr_j == w_arr_i) && (r_j < r_i));
  assign w_acc_next = r_acc + IDXW'(w_less);

  sort_buffer #(.N(N), .W(W), .IDXW(IDXW)) u_arr (
    .clk       (clk),
    .i_we      (w_in_fire),
    .i_waddr   (r_ld_cnt),
    .i_wdata   (in_data),
    .i_raddr_a (r_i),
    .i_raddr_b (r_j),
    .o_rdata_a (w_arr_i),
    .o_rdata_b (w_arr_j)
  );

  sort_buffer #(.N(N), .W(W), .IDXW(IDXW)) u_res (
    .clk       (clk),
    .i_we      (r_state == SCATTER),
    .i_waddr   (r_rank[r_i]),
    .i_wdata   (w_arr_i),
    .i_raddr_a (r_out_ptr),
    .i_raddr_b (r_out_ptr),
    .o_rdata_a (w_res_data),
    .o_rdata_b (w_res_unused)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= LOAD;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LOAD:    if (w_in_fire && (r_ld_cnt == LAST))      w_next_state = COUNT;
      COUNT:   if (w_row_end && (r_i == LAST))           w_next_state = SCATTER;
      SCATTER: if (r_i == LAST)                          w_next_state = OUT;
      OUT:     if (w_out_fire && (r_out_ptr == LAST))    w_next_state = LOAD;
      default:                                           w_next_state = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    out_data  = '0;
    out_index = '0;
    done      = r_done;
    case (r_state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      OUT: begin
        out_valid = 1'b1;
        out_data  = w_res_data;
        out_index = r_out_ptr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_cnt  <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_acc     <= '0;
      r_out_ptr <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_in_fire) begin
            if (r_ld_cnt == LAST) begin
              r_ld_cnt <= '0;
              r_i      <= '0;
              r_j      <= '0;
              r_acc    <= '0;
            end else begin
              r_ld_cnt <= r_ld_cnt + ONE;
            end
          end
        end
        COUNT: begin
          if (w_row_end) begin
            r_acc <= '0;
            r_j   <= '0;
            r_i   <= (r_i == LAST) ? '0 : r_i + ONE;
          end else begin
            r_acc <= w_acc_next;
            r_j   <= r_j + ONE;
          end
        end
        SCATTER: begin
          r_i <= (r_i == LAST) ? '0 : r_i + ONE;
          if (r_i == LAST) r_out_ptr <= '0;
        end
        OUT: begin
          if (w_out_fire) begin
            if (r_out_ptr == LAST) begin
              r_out_ptr <= '0;
              r_done    <= 1'b1;
            end else begin
              r_out_ptr <= r_out_ptr + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == COUNT) && w_row_end) r_rank[r_i] <= w_acc_next;
  end

endmodule
